// File: rtl/pipe_pkg.sv
// Shared types and helpers for the elastic inter-stage pipeline register.
// Optional statistics counters are enabled with PIPE_STAGE_STATS_EN.
package pipe_pkg;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        FULL  = 2'd2
    } pipe_state_t;

    localparam int STAT_W = 16;

    // Width of the squash-window counter: enough to hold FLUSH_CYC-1 and 0.
    function automatic int flush_cnt_w(input int flush_cyc);
        return $clog2(flush_cyc + 1);
    endfunction

endpackage

// File: rtl/pipe_stage_elastic_slot.sv
// One storage slot (valid, data, ctrl) of the elastic stage.
// Clear drops valid and ctrl but keeps data; load of an invalid beat keeps data/ctrl.
module pipe_slot #(
    parameter int DATA_W = 16,
    parameter int CTRL_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              load_i,
    input  logic              clr_i,
    input  logic              valid_i,
    input  logic [DATA_W-1:0] data_i,
    input  logic [CTRL_W-1:0] ctrl_i,
    output logic              valid_o,
    output logic [DATA_W-1:0] data_o,
    output logic [CTRL_W-1:0] ctrl_o
);

    logic              valid_q;
    logic [DATA_W-1:0] data_q;
    logic [CTRL_W-1:0] ctrl_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_q <= 1'b0;
            data_q  <= '0;
            ctrl_q  <= '0;
        end else if (clr_i) begin
            valid_q <= 1'b0;
            ctrl_q  <= '0;
        end else if (load_i) begin
            valid_q <= valid_i;
            if (valid_i) begin
                data_q <= data_i;
                ctrl_q <= ctrl_i;
            end
        end
    end

    assign valid_o = valid_q;
    assign data_o  = data_q;
    assign ctrl_o  = ctrl_q;

endmodule

// File: rtl/pipe_stage_elastic.sv
// Elastic pipeline register: main + skid slot, registered backpressure, flush squash window.
// Define PIPE_STAGE_STATS_EN to add the stall_cycles / squashed_beats counters.
module pipe_stage_elastic
    import pipe_pkg::*;
#(
    parameter int DATA_W    = 16,
    parameter int CTRL_W    = 8,
    parameter int FLUSH_CYC = 3,
    localparam int FCW      = flush_cnt_w(FLUSH_CYC)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    input  logic [CTRL_W-1:0] in_ctrl,
    input  logic              flush,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [CTRL_W-1:0] out_ctrl,
    output logic              flush_active,
    output logic [FCW-1:0]    flush_cnt
`ifdef PIPE_STAGE_STATS_EN
    ,
    output logic [STAT_W-1:0] stall_cycles,
    output logic [STAT_W-1:0] squashed_beats
`endif
);

    // Handshake: a beat transfers on a rising edge where valid & ready are both high;
    // valid never depends on ready, and in_ready comes straight from the skid valid flop.
    logic              main_v, skid_v;
    logic [DATA_W-1:0] main_data, skid_data;
    logic [CTRL_W-1:0] main_ctrl, skid_ctrl;

    logic              squash, acc, pop;
    logic              main_load, main_from_skid, main_vin;
    logic              skid_load, skid_vin;
    logic [DATA_W-1:0] main_data_in;
    logic [CTRL_W-1:0] main_ctrl_in;
    logic [FCW-1:0]    flush_cnt_q, flush_cnt_d;
    pipe_state_t       state;

    assign squash = flush | (flush_cnt_q != '0);
    assign acc    = in_valid & in_ready & ~squash;
    assign pop    = out_valid & out_ready;

    // The slot valid bits are the state register; this decodes them.
    always_comb begin
        state = EMPTY;
        if (main_v) begin
            state = skid_v ? FULL : ONE;
        end
    end

    always_comb begin
        main_load      = 1'b0;
        main_from_skid = 1'b0;
        main_vin       = 1'b0;
        skid_load      = 1'b0;
        skid_vin       = 1'b0;
        case (state)
            EMPTY: begin
                if (acc) begin
                    main_load = 1'b1;
                    main_vin  = 1'b1;
                end
            end
            ONE: begin
                if (pop) begin
                    main_load = 1'b1;
                    main_vin  = acc;
                end else if (acc) begin
                    skid_load = 1'b1;
                    skid_vin  = 1'b1;
                end
            end
            FULL: begin
                if (pop) begin
                    main_load      = 1'b1;
                    main_from_skid = 1'b1;
                    main_vin       = 1'b1;
                    skid_load      = 1'b1;
                    skid_vin       = 1'b0;
                end
            end
            default: begin
            end
        endcase
    end

    always_comb begin
        main_data_in = main_from_skid ? skid_data : in_data;
        main_ctrl_in = main_from_skid ? skid_ctrl : in_ctrl;
    end

    pipe_slot #(.DATA_W(DATA_W), .CTRL_W(CTRL_W)) u_main (
        .clk     (clk),
        .rst     (rst),
        .load_i  (main_load),
        .clr_i   (flush),
        .valid_i (main_vin),
        .data_i  (main_data_in),
        .ctrl_i  (main_ctrl_in),
        .valid_o (main_v),
        .data_o  (main_data),
        .ctrl_o  (main_ctrl)
    );

    pipe_slot #(.DATA_W(DATA_W), .CTRL_W(CTRL_W)) u_skid (
        .clk     (clk),
        .rst     (rst),
        .load_i  (skid_load),
        .clr_i   (flush),
        .valid_i (skid_vin),
        .data_i  (in_data),
        .ctrl_i  (in_ctrl),
        .valid_o (skid_v),
        .data_o  (skid_data),
        .ctrl_o  (skid_ctrl)
    );

    // A flush during an open window restarts it rather than extending it additively.
    always_comb begin
        flush_cnt_d = flush_cnt_q;
        if (flush) begin
            flush_cnt_d = FCW'(FLUSH_CYC - 1);
        end else if (flush_cnt_q != '0) begin
            flush_cnt_d = flush_cnt_q - FCW'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            flush_cnt_q <= '0;
        end else begin
            flush_cnt_q <= flush_cnt_d;
        end
    end

    assign in_ready     = ~skid_v;
    assign out_valid    = main_v;
    assign out_data     = main_data;
    assign out_ctrl     = main_ctrl;
    assign flush_active = (flush_cnt_q != '0);
    assign flush_cnt    = flush_cnt_q;

`ifdef PIPE_STAGE_STATS_EN
    logic [STAT_W-1:0] stall_q, squashed_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stall_q    <= '0;
            squashed_q <= '0;
        end else begin
            if (out_valid && !out_ready && (stall_q != '1)) begin
                stall_q <= stall_q + STAT_W'(1);
            end
            if (in_valid && squash && (squashed_q != '1)) begin
                squashed_q <= squashed_q + STAT_W'(1);
            end
        end
    end

    assign stall_cycles   = stall_q;
    assign squashed_beats = squashed_q;
`endif

endmodule
